booth_mac_sequencer: RTL and testbench
======================================

// Module: booth_mac_sequencer
// PURPOSE
//  Multi-cycle signed multiply-accumulate controller for the FMAC datapath.
//  Accepts operands a, b and addend c, then retires one radix-4 Booth partial product per cycle.
//  Each partial product is sign-extended, shifted and added into a running accumulator.
//  Returns a*b + c through a valid/ready handshake.
//  Owns the partial-product index and first-partial-product flag (pp_first) that steer the sign-extension stage.
// PARAMETERS
//  W     8     operand width (a, b); even, >= 4
//  NPP   W/2   number of Booth partial products (derived, localparam)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     reset, asynchronous, active-high
//  in_valid   in   1     operands a/b/c valid
//  in_ready   out  1     sequencer can accept operands
//  a          in   W     multiplicand, two's complement
//  b          in   W     multiplier, two's complement (Booth-recoded)
//  c          in   2W    addend, two's complement
//  res_valid  out  1     result valid, held until consumed
//  res_ready  in   1     consumer accepts result
//  res        out  2W    (a*b + c) mod 2^(2W), two's complement
//  busy       out  1     high in RUN or DONE
//  pp_first   out  1     high while partial product 0 is being accumulated
// BEHAVIOUR
//  Reset (async, any cycle, including mid-RUN)
//   - State goes to IDLE; counter, accumulator and operand registers clear to 0.
//   - Outputs: in_ready=1, res_valid=0, res=0, busy=0, pp_first=0.
//   - Any in-flight operation is discarded.
//  States: IDLE, RUN, DONE
//  IDLE
//   - in_ready=1.
//   - On in_valid: latch a, b, c; acc<=sext(c); idx<=0; go to RUN.
//  RUN (in_ready=0, busy=1)
//   - Booth digit d = -2*b[2i+1] + b[2i] + b[2i-1], with i=idx and b[-1]=0.
//   - pp = d*a as a W+2-bit signed value (0, +-a, +-2a); -a/-2a formed as ~x+1.
//   - acc <= acc + (sext(pp) << 2i), computed mod 2^(2W+2).
//   - pp_first = (idx==0).
//   - When idx==NPP-1, go to DONE; otherwise idx<=idx+1.
//  DONE (busy=1)
//   - res_valid=1 and res=acc[2W-1:0]; res is stable while res_valid.
//   - On res_ready, go to IDLE; res_valid falls next cycle and res holds its last value.
//  Latency and throughput
//   - Accept edge to res_valid: exactly NPP+1 cycles.
//   - Minimum initiation interval: NPP+2 cycles.
//   - No overlap: in_ready=0 in RUN and in DONE.
//  in_valid while not ready: ignored, nothing latched.
//  Overflow: silent wrap mod 2^(2W), no flag. a*b alone never overflows 2W bits.
//  res_ready while res_valid=0: ignored.
// STRUCTURE
//  Shared package (fmac_pkg)
//   - State enum codes {IDLE=2'd0, RUN=2'd1, DONE=2'd2}.
//   - Booth digit encoding (3-bit one-hot-ish {neg, two, one}).
//   - Default W.
//  Sub-module booth_pp_select
//   - Combinational.
//   - Inputs: a, 3-bit recode window. Output: W+2-bit signed partial product.
//  This block holds the FSM, idx counter, operand/accumulator registers and adder.
// TESTING
//  1. W=8; a=3, b=5, c=0 -> res_valid exactly 5 cycles after accept; res=16'h000F.
//  2. a=-128, b=-128, c=0 -> res=16'h4000 (16384); pp_first high in first RUN cycle only.
//  3. a=127, b=-128, c=100 -> res = -16256+100 = 16'hC0E4.
//  4. a=-128, b=-128, c=32767 -> wraps to res=16'hBFFF, no error.
//  5. Back-pressure: hold res_ready=0 for 10 cycles -> res/res_valid stable, in_ready=0;
//     in_valid pulses ignored; after res_ready, next op accepted.
//  6. Assert rst in 2nd RUN cycle -> same-cycle async clear to reset values;
//     a fresh op after release gives the correct result.

Source files
------------

// File: rtl/fmac_pkg.sv
// -----------------------------------------------------------------------------
// fmac_pkg
// Shared definitions for the FMAC multiply-accumulate datapath:
//   - sequencer state encoding
//   - radix-4 Booth digit encoding {neg, two, one}
//   - default operand width
//   - booth_encode(): maps a 3-bit recode window {b[2i+1], b[2i], b[2i-1]}
//     to its Booth digit
// -----------------------------------------------------------------------------
package fmac_pkg;

    // Default operand width for a and b. Must be even and at least 4.
    localparam int FMAC_DEFAULT_W = 8;

    // Sequencer states. The codes are fixed so they read the same in
    // waveforms across every block that imports this package.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fmac_state_e;

    // Booth digit in sign/magnitude form.
    //   one : magnitude is 1 (select a)
    //   two : magnitude is 2 (select a << 1)
    //   neg : negate the selected magnitude
    // A zero digit has every bit clear.
    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_dig_t;

    // Window bits are {b[2i+1], b[2i], b[2i-1]}. The digit value is
    // -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic booth_dig_t booth_encode(input logic [2:0] win);
        booth_dig_t dig;
        case (win)
            3'b000:  dig = '{neg: 1'b0, two: 1'b0, one: 1'b0};  //  0
            3'b001:  dig = '{neg: 1'b0, two: 1'b0, one: 1'b1};  // +1
            3'b010:  dig = '{neg: 1'b0, two: 1'b0, one: 1'b1};  // +1
            3'b011:  dig = '{neg: 1'b0, two: 1'b1, one: 1'b0};  // +2
            3'b100:  dig = '{neg: 1'b1, two: 1'b1, one: 1'b0};  // -2
            3'b101:  dig = '{neg: 1'b1, two: 1'b0, one: 1'b1};  // -1
            3'b110:  dig = '{neg: 1'b1, two: 1'b0, one: 1'b1};  // -1
            3'b111:  dig = '{neg: 1'b0, two: 1'b0, one: 1'b0};  //  0 (-0)
            default: dig = '{neg: 1'b0, two: 1'b0, one: 1'b0};
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// -----------------------------------------------------------------------------
// booth_pp_select
// Combinational radix-4 Booth partial-product generator. It recodes one
// 3-bit window of the multiplier and returns digit * a as a W+2-bit
// two's-complement value. The result is one of 0, +a, -a, +2a or -2a.
//
// Ports
//   a_i    [W-1:0]  multiplicand, two's complement
//   win_i  [2:0]    recode window {b[2i+1], b[2i], b[2i-1]}
//   pp_o   [W+1:0]  signed partial product
// -----------------------------------------------------------------------------
module booth_pp_select
    import fmac_pkg::*;
#(
    parameter int W = FMAC_DEFAULT_W
)(
    input  logic [W-1:0] a_i,
    input  logic [2:0]   win_i,
    output logic [W+1:0] pp_o
);

    booth_dig_t   dig_s;
    logic [W+1:0] mag_s;

    // Recode the window and select the magnitude: a or 2a, sign-extended to W+2 bits.
    // W+2 bits cover every case, including -(-2^(W-1) * 2) = +2^W.
    always_comb begin
        dig_s = booth_encode(win_i);
        mag_s = {(W + 2){1'b0}};
        if (dig_s.two) begin
            mag_s = {a_i[W-1], a_i, 1'b0};
        end else if (dig_s.one) begin
            mag_s = {{2{a_i[W-1]}}, a_i};
        end else begin
            mag_s = {(W + 2){1'b0}};
        end
    end

    // Negate by inverting and adding one. Negating zero (-0) gives zero.
    always_comb begin
        pp_o = mag_s;
        if (dig_s.neg) begin
            pp_o = ~mag_s + {{(W + 1){1'b0}}, 1'b1};
        end else begin
            pp_o = mag_s;
        end
    end

endmodule

// File: rtl/booth_mac_sequencer.sv
// -----------------------------------------------------------------------------
// booth_mac_sequencer
// Multi-cycle signed multiply-accumulate: res = (a*b + c) mod 2^(2W).
// After an accept, the block retires one radix-4 Booth partial product per
// cycle (W/2 cycles in RUN). The result is then held in DONE until the
// consumer takes it.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   a/b/c valid            in_ready   operands accepted in IDLE
//   a [W-1:0]  multiplicand           b [W-1:0]  multiplier (Booth-recoded)
//   c [2W-1:0] addend
//   res_valid  result valid (held)    res_ready  consumer takes result
//   res [2W-1:0] result, stable while res_valid and held after it falls
//   busy       high in RUN or DONE
//   pp_first   high while partial product 0 is being accumulated
//
// All outputs come straight from flops. Each output flop is loaded from a
// decode of the next state, so it changes on the same edge as the state.
// -----------------------------------------------------------------------------
module booth_mac_sequencer
    import fmac_pkg::*;
#(
    parameter int W = FMAC_DEFAULT_W
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2*W-1:0] c,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res,
    output logic           busy,
    output logic           pp_first
);

    localparam int NPP = W / 2;
    localparam int IW  = (NPP > 1) ? $clog2(NPP) : 1;
    // Two guard bits let the internal sum wrap mod 2^(2W+2). Only the
    // low 2W bits are ever reported.
    localparam int AW  = 2 * W + 2;
    localparam logic [IW-1:0] IDX_LAST = IW'(NPP - 1);

    // State and datapath registers
    fmac_state_e     state_q,     state_d;
    logic [IW-1:0]   idx_q,       idx_d;
    logic [W-1:0]    a_q,         a_d;
    logic [W-1:0]    b_q,         b_d;
    logic [AW-1:0]   acc_q,       acc_d;
    logic [2*W-1:0]  res_q,       res_d;

    // Output registers
    logic            in_ready_q,  in_ready_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q,      busy_d;
    logic            pp_first_q,  pp_first_d;

    // Datapath signals
    logic [W:0]      b_ext_s;
    logic [2:0]      win_arr_s [NPP];
    logic [2:0]      win_s;
    logic [W+1:0]    pp_s;
    logic [AW-1:0]   pp_ext_s;
    logic [IW:0]     shamt_s;
    logic [AW-1:0]   acc_sum_s;

    // Build every recode window from b with the implicit b[-1]=0 appended. The current index then picks one window.
    always_comb begin
        b_ext_s = {b_q, 1'b0};
        for (int k = 0; k < NPP; k++) begin
            win_arr_s[k] = b_ext_s[2*k +: 3];
        end
        win_s = win_arr_s[idx_q];
    end

    booth_pp_select #(
        .W (W)
    ) u_pp_select (
        .a_i   (a_q),
        .win_i (win_s),
        .pp_o  (pp_s)
    );

    // Sign-extend the partial product to accumulator width and weight it by 4^idx.
    always_comb begin
        pp_ext_s  = {{W{pp_s[W+1]}}, pp_s};
        shamt_s   = {idx_q, 1'b0};
        acc_sum_s = acc_q + (pp_ext_s << shamt_s);
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = {{2{c[2*W-1]}}, c};
                    idx_d   = {IW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum_s;
                if (idx_q == IDX_LAST) begin
                    // Capture the final sum now so that res is already valid
                    // on the first DONE cycle.
                    res_d   = acc_sum_s[2*W-1:0];
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decode output flop next values from the next state.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        pp_first_d  = (state_d == ST_RUN) && (idx_d == {IW{1'b0}});
    end

    // State, datapath and output registers. The asynchronous reset drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IW{1'b0}};
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            acc_q       <= {AW{1'b0}};
            res_q       <= {(2 * W){1'b0}};
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            pp_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            pp_first_q  <= pp_first_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res       = res_q;
    assign busy      = busy_q;
    assign pp_first  = pp_first_q;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for booth_mac_sequencer with W=8.
// The reference result is plain integer arithmetic, (a*b + c) mod 2^16.
// Timing expectations are counted in clock edges, with the accept edge as
// edge 1.
// -----------------------------------------------------------------------------
module tb_booth_mac_sequencer;

    localparam int W   = 8;
    localparam int NPP = W / 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] c;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res;
    logic           busy;
    logic           pp_first;

    int pass_cnt  = 0;
    int total_cnt = 0;

    booth_mac_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .busy      (busy),
        .pp_first  (pp_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: signed product plus signed addend, truncated to 2W bits.
    function automatic logic [2*W-1:0] model_mac(input logic [W-1:0] a_v,
                                                 input logic [W-1:0] b_v,
                                                 input logic [2*W-1:0] c_v);
        longint r;
        r = longint'($signed(a_v)) * longint'($signed(b_v)) + longint'($signed(c_v));
        return r[2*W-1:0];
    endfunction

    // Present one operand set. Wait until res_valid or the cycle budget runs out.
    task automatic start_and_wait(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                  input logic [2*W-1:0] c_v,
                                  output int lat, output int ppf_cnt,
                                  output logic ppf_at_first, output logic timed_out);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = a_v; b = b_v; c = c_v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        lat          = 1;
        ppf_at_first = pp_first;
        ppf_cnt      = (pp_first === 1'b1) ? 1 : 0;
        timed_out    = 1'b0;
        while (res_valid !== 1'b1) begin
            if (lat >= 50) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
            if (pp_first === 1'b1) ppf_cnt++;
        end
    endtask

    // Hold off the consumer for a number of cycles, then take the result.
    task automatic consume(input int hold);
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        in_valid = 1'b1;     // must be ignored while reset is held
        #2;
        total_cnt++;
        if ({in_ready, res_valid, res, busy, pp_first} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_async: got rdy=%b vld=%b res=%h busy=%b ppf=%b, want 1 0 0000 0 0",
                     in_ready, res_valid, res, busy, pp_first);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({in_ready, res_valid, busy} !== 3'b100)
            $display("FAIL reset_release: got rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, res_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [W-1:0]   av [4] = '{8'd3, 8'h80, 8'd127, 8'h80};
        logic [W-1:0]   bv [4] = '{8'd5, 8'h80, 8'h80, 8'h80};
        logic [2*W-1:0] cv [4] = '{16'd0, 16'd0, 16'd100, 16'd32767};
        logic [2*W-1:0] ev [4] = '{16'h000F, 16'h4000, 16'hC0E4, 16'hBFFF};
        int lat, ppf_cnt;
        logic ppf0, tmo;
        logic [2*W-1:0] held;
        for (int i = 0; i < 4; i++) begin
            start_and_wait(av[i], bv[i], cv[i], lat, ppf_cnt, ppf0, tmo);
            total_cnt++;
            if (tmo || lat != NPP + 1)
                $display("FAIL dir%0d_latency: got %0d (timeout=%b), want %0d", i, lat, tmo, NPP + 1);
            else pass_cnt++;
            total_cnt++;
            if (res !== ev[i]) $display("FAIL dir%0d_res: got %h, want %h", i, res, ev[i]);
            else pass_cnt++;
            total_cnt++;
            if (ppf0 !== 1'b1 || ppf_cnt != 1)
                $display("FAIL dir%0d_pp_first: first=%b count=%0d, want first=1 count=1", i, ppf0, ppf_cnt);
            else pass_cnt++;
            total_cnt++;
            if ({busy, in_ready} !== 2'b10)
                $display("FAIL dir%0d_done_flags: busy=%b rdy=%b, want 1 0", i, busy, in_ready);
            else pass_cnt++;
            held = res;
            consume(0);
            total_cnt++;
            if ({res_valid, in_ready, busy} !== 3'b010 || res !== held)
                $display("FAIL dir%0d_retire: vld=%b rdy=%b busy=%b res=%h, want 0 1 0 %h",
                         i, res_valid, in_ready, busy, res, held);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv;
        logic [2*W-1:0] cv, exp_r;
        int lat, ppf_cnt;
        logic ppf0, tmo;
        for (int i = 0; i < 30; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            cv = (2*W)'($urandom);
            exp_r = model_mac(av, bv, cv);
            start_and_wait(av, bv, cv, lat, ppf_cnt, ppf0, tmo);
            total_cnt++;
            if (tmo || lat != NPP + 1 || res !== exp_r)
                $display("FAIL rand%0d: a=%h b=%h c=%h got res=%h lat=%0d, want res=%h lat=%0d",
                         i, av, bv, cv, res, lat, exp_r, NPP + 1);
            else pass_cnt++;
            consume(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] exp_r, exp2;
        int lat, ppf_cnt;
        logic ppf0, tmo;
        exp_r = model_mac(8'hD3, 8'h6B, 16'h1234);
        start_and_wait(8'hD3, 8'h6B, 16'h1234, lat, ppf_cnt, ppf0, tmo);
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            // Offered operands must be ignored while DONE holds the result.
            in_valid = i[0];
            a = W'($urandom); b = W'($urandom); c = (2*W)'($urandom);
            @(posedge clk); #1;
            total_cnt++;
            if (res !== exp_r || res_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL bp_hold%0d: res=%h vld=%b rdy=%b busy=%b, want %h 1 0 1",
                         i, res, res_valid, in_ready, busy, exp_r);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        consume(0);
        total_cnt++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || res !== exp_r)
            $display("FAIL bp_release: vld=%b rdy=%b res=%h, want 0 1 %h", res_valid, in_ready, res, exp_r);
        else pass_cnt++;
        exp2 = model_mac(8'h7F, 8'h7F, 16'hFFFF);
        start_and_wait(8'h7F, 8'h7F, 16'hFFFF, lat, ppf_cnt, ppf0, tmo);
        total_cnt++;
        if (tmo || res !== exp2) $display("FAIL bp_next_op: got %h, want %h", res, exp2);
        else pass_cnt++;
        consume(0);
    endtask

    task automatic test_reset_mid_run();
        logic [2*W-1:0] exp2;
        int lat, ppf_cnt;
        logic ppf0, tmo;
        a = 8'h5A; b = 8'hC3; c = 16'h0777; in_valid = 1'b1;
        @(posedge clk); #1;          // accept edge: first RUN cycle
        in_valid = 1'b0;
        @(posedge clk); #1;          // second RUN cycle
        total_cnt++;
        if (busy !== 1'b1 || pp_first !== 1'b0)
            $display("FAIL rst_mid_pre: busy=%b ppf=%b, want 1 0", busy, pp_first);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({in_ready, res_valid, res, busy, pp_first} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL rst_mid_clear: rdy=%b vld=%b res=%h busy=%b ppf=%b, want 1 0 0000 0 0",
                     in_ready, res_valid, res, busy, pp_first);
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        exp2 = model_mac(8'h81, 8'h55, 16'h8001);
        start_and_wait(8'h81, 8'h55, 16'h8001, lat, ppf_cnt, ppf0, tmo);
        total_cnt++;
        if (tmo || lat != NPP + 1 || res !== exp2)
            $display("FAIL rst_mid_fresh: got %h lat=%0d, want %h lat=%0d", res, lat, exp2, NPP + 1);
        else pass_cnt++;
        consume(0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic [2*W-1:0] c1, c2, r1;
        logic seen;
        int k, guard;
        a1 = W'($urandom); b1 = W'($urandom); c1 = (2*W)'($urandom);
        a2 = W'($urandom); b2 = W'($urandom); c2 = (2*W)'($urandom);
        res_ready = 1'b1;
        a = a1; b = b1; c = c1; in_valid = 1'b1;
        @(posedge clk); #1;          // first accept
        a = a2; b = b2; c = c2;      // keep in_valid high with the next operands
        k = 0; seen = 1'b0; r1 = '0;
        while (in_ready !== 1'b1 && k < 50) begin
            if (res_valid === 1'b1) begin
                seen = 1'b1;
                r1 = res;
            end
            @(posedge clk); #1;
            k++;
        end
        total_cnt++;
        if (!seen || r1 !== model_mac(a1, b1, c1))
            $display("FAIL b2b_res1: seen=%b got %h, want %h", seen, r1, model_mac(a1, b1, c1));
        else pass_cnt++;
        total_cnt++;
        if (k + 1 != NPP + 2) $display("FAIL b2b_interval: got %0d, want %0d", k + 1, NPP + 2);
        else pass_cnt++;
        @(posedge clk); #1;          // second accept
        in_valid = 1'b0;
        guard = 0;
        while (res_valid !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        total_cnt++;
        if (res_valid !== 1'b1 || res !== model_mac(a2, b2, c2))
            $display("FAIL b2b_res2: vld=%b got %h, want %h", res_valid, res, model_mac(a2, b2, c2));
        else pass_cnt++;
        @(posedge clk); #1;
        res_ready = 1'b0;
        total_cnt++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_retire: vld=%b rdy=%b, want 0 1", res_valid, in_ready);
        else pass_cnt++;
    endtask

    initial begin
        in_valid  = 1'b0;
        res_ready = 1'b0;
        a = '0; b = '0; c = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
